// File: rtl/onehot_decoder_seq_if.sv
// Bundle for the registered one-hot decoder: the control FSM side drives the
// request signals, the decoder drives the registered select and sweep status.
interface onehot_decoder_seq_if #(
  parameter int IN_W = 5
);
  localparam int OUT_W = 2**IN_W;

  logic              en;
  logic [IN_W-1:0]   d;
  logic              clr_start;
  logic [OUT_W-1:0]  q;
  logic              q_valid;
  logic              busy;
  logic              clr_done;

  modport master (
    output en, d, clr_start,
    input  q, q_valid, busy, clr_done
  );

  modport slave (
    input  en, d, clr_start,
    output q, q_valid, busy, clr_done
  );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered IN_W-to-2**IN_W one-hot decoder with a self-timed sweep for bulk
// register-file clear. Define ONEHOT_DEC_ACTIVE_LOW_EN for a one-cold q.
module onehot_decoder_seq #(
  parameter int IN_W  = 5,
  parameter int CNT_W = IN_W
) (
  input  logic              clk,
  input  logic              reset,
  onehot_decoder_seq_if.slave bus
);
  localparam int OUT_W = 2**IN_W;

`ifdef ONEHOT_DEC_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] Q_IDLE = '1;
`else
  localparam logic [OUT_W-1:0] Q_IDLE = '0;
`endif

  if (CNT_W != IN_W) begin : g_cfg_err
    $error("onehot_decoder_seq: CNT_W must equal IN_W");
  end

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // XOR with the idle pattern turns the one-hot into one-cold when active-low.
  function automatic logic [OUT_W-1:0] sel(input logic [IN_W-1:0] idx);
    return (OUT_W'(1) << idx) ^ Q_IDLE;
  endfunction

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.q        <= Q_IDLE;
      bus.q_valid  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.clr_done <= 1'b0;
          if (bus.clr_start) begin
            // A coincident en request is dropped, not queued.
            state       <= SWEEP;
            cnt         <= '0;
            bus.q       <= sel('0);
            bus.q_valid <= 1'b1;
            bus.busy    <= 1'b1;
          end else if (bus.en) begin
            bus.q       <= sel(bus.d);
            bus.q_valid <= 1'b1;
          end else begin
            bus.q       <= Q_IDLE;
            bus.q_valid <= 1'b0;
          end
        end

        SWEEP: begin
          if (cnt == CNT_W'(OUT_W - 1)) begin
            state        <= DONE;
            bus.q        <= Q_IDLE;
            bus.q_valid  <= 1'b0;
            bus.clr_done <= 1'b1;
          end else begin
            cnt         <= CNT_W'(cnt + 1'b1);
            bus.q       <= sel(CNT_W'(cnt + 1'b1));
            bus.q_valid <= 1'b1;
          end
        end

        DONE: begin
          state        <= IDLE;
          cnt          <= '0;
          bus.q        <= Q_IDLE;
          bus.q_valid  <= 1'b0;
          bus.busy     <= 1'b0;
          bus.clr_done <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          cnt          <= '0;
          bus.q        <= Q_IDLE;
          bus.q_valid  <= 1'b0;
          bus.busy     <= 1'b0;
          bus.clr_done <= 1'b0;
        end
      endcase
    end
  end
endmodule
